mem_ctrl: RTL and testbench

Word-addressed on-chip memory controller sitting directly downstream of the core's single memory port. It accepts the core's level-held read/write requests (`mem_read`/`mem_write`, `mem_addr`, `mem_wdata`). It answers each one with a single-cycle `mem_resp` after a fixed, parameterised latency, serving from an internal RAM array. It also provides a small simulation MMIO window.

---
 rtl/mem_ctrl_if.sv | 20 ++
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Core-side memory port: level-held read/write request with a one-cycle
// completion pulse carrying read data.
interface mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_ctrl.sv
// Fixed-latency on-chip RAM controller for the core memory port.
// Define MEM_MMIO_EN to enable the console/halt MMIO window at 0xFFFF_0000.
module mem_ctrl #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_ctrl_if.slave  bus,
    output logic       err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       halt
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [31:0] TX_ADDR   = 32'hFFFF_0000;
    localparam logic [31:0] HALT_ADDR = 32'hFFFF_0004;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, wdata_q;
    logic        rd_q, wr_q;

    logic [31:0] op_addr, op_wdata, off;
    logic        op_rd, op_wr;
    logic        access, in_range, mmio_tx, mmio_halt, ram_we;
    logic [IDX_W-1:0] idx;

    logic [31:0] ram [DEPTH_WORDS];

    // With LATENCY==1 the access happens on the accepting edge, so operands
    // come straight from the bus while IDLE and from the latches afterwards.
    always_comb begin
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_rd    = rd_q;
        op_wr    = wr_q;
        if (state == IDLE) begin
            op_addr  = bus.mem_addr;
            op_wdata = bus.mem_wdata;
            op_rd    = bus.mem_read;
            op_wr    = bus.mem_write;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign access   = (state != RESP) && (state_nxt == RESP);
    assign off      = op_addr - BASE_ADDR;
    assign in_range = {1'b0, off} < SPAN;
    assign idx      = off[IDX_W+1:2];

`ifdef MEM_MMIO_EN
    assign mmio_tx   = op_addr[31:2] == TX_ADDR[31:2];
    assign mmio_halt = op_addr[31:2] == HALT_ADDR[31:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            halt     <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (access && op_wr && mmio_tx) begin
                tx_data  <= op_wdata[7:0];
                tx_valid <= 1'b1;
            end
            if (access && op_wr && mmio_halt) halt <= 1'b1;
        end
    end
`else
    assign mmio_tx   = 1'b0;
    assign mmio_halt = 1'b0;
    assign tx_data   = 8'h00;
    assign tx_valid  = 1'b0;
    assign halt      = 1'b0;
`endif

    // Both request lines together resolve as a write.
    assign ram_we = access && op_wr && !mmio_tx && !mmio_halt && in_range;

    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= op_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            bus.mem_rdata <= 32'h0;
            err           <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                rd_q    <= bus.mem_read;
                wr_q    <= bus.mem_write;
            end
            if (access) begin
                if (op_rd && op_wr) err <= 1'b1;
                if (op_wr) begin
                    if (!mmio_tx && !mmio_halt && !in_range) err <= 1'b1;
                end else if (mmio_tx) begin
                    bus.mem_rdata <= 32'h0;
                end else if (mmio_halt) begin
                    bus.mem_rdata <= {31'b0, halt};
                end else if (in_range) begin
                    bus.mem_rdata <= ram[idx];
                end else begin
                    bus.mem_rdata <= 32'h0;
                    err           <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_resp = (state == RESP);
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed tables, hand sequences for
// reset/latency corners, and random traffic against a spec-level model.
module tb_mem_ctrl;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          LAT   = 2;
`ifdef MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if bus0();
    mem_ctrl_if bus1();
    logic       err0, tx_valid0, halt0, err1, tx_valid1, halt1;
    logic [7:0] tx_data0, tx_data1;

    mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .err(err0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .halt(halt0));

    mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .err(err1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .halt(halt1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word-indexed sparse memory plus observable flags.
    logic [31:0] m_mem [int unsigned];
    bit          m_err;
    bit          m_halt;
    logic [31:0] m_rdata;
    logic [7:0]  m_tx;

    task automatic model_reset();
        m_err = 0; m_halt = 0; m_rdata = 0; m_tx = 0;
    endtask

    task automatic model(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output bit etx);
        logic [31:0] o;
        bit inr, ta, ha;
        int unsigned w;
        o   = a - BASE;
        inr = 64'(o) < 64'(DEPTH) * 4;
        w   = o / 4;
        ta  = MMIO && (a / 4 == 32'hFFFF_0000 / 4);
        ha  = MMIO && (a / 4 == 32'hFFFF_0004 / 4);
        etx = 0;
        if (rd && wr) m_err = 1;
        if (wr) begin
            if (ta) begin m_tx = d[7:0]; etx = 1; end
            else if (ha) m_halt = 1;
            else if (inr) m_mem[w] = d;
            else m_err = 1;
        end else begin
            if (ta) m_rdata = 0;
            else if (ha) m_rdata = {31'b0, m_halt};
            else if (inr) m_rdata = m_mem.exists(w) ? m_mem[w] : 32'h0;
            else begin m_rdata = 0; m_err = 1; end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_resp"},     32'(bus0.mem_resp), 32'h0);
        check({tag, "_rdata"},    bus0.mem_rdata,     32'h0);
        check({tag, "_err"},      32'(err0),          32'h0);
        check({tag, "_tx_data"},  32'(tx_data0),      32'h0);
        check({tag, "_tx_valid"}, 32'(tx_valid0),     32'h0);
        check({tag, "_halt"},     32'(halt0),         32'h0);
    endtask

    // One transaction on dut; called at a negedge while dut is IDLE.
    // Address/data are scrambled after acceptance to prove they are latched.
    task automatic xact(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        bit etx;
        int n;
        model(rd, wr, a, d, etx);
        bus0.mem_read = rd; bus0.mem_write = wr;
        bus0.mem_addr = a;  bus0.mem_wdata = d;
        n = 0;
        do begin
            @(posedge clk); @(negedge clk); n++;
            if (n == 1) begin bus0.mem_addr = $urandom; bus0.mem_wdata = $urandom; end
        end while (!bus0.mem_resp && n < 20);
        check({tag, "_latency"},  32'(n),         32'(LAT));
        check({tag, "_rdata"},    bus0.mem_rdata, m_rdata);
        check({tag, "_err"},      32'(err0),      32'(m_err));
        check({tag, "_tx_valid"}, 32'(tx_valid0), 32'(etx));
        check({tag, "_tx_data"},  32'(tx_data0),  32'(m_tx));
        check({tag, "_halt"},     32'(halt0),     32'(m_halt));
        bus0.mem_read = 0; bus0.mem_write = 0;
        @(negedge clk);
        check({tag, "_resp_pulse"}, 32'({bus0.mem_resp, tx_valid0}), 32'h0);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t good_tbl[6];
    vec_t bad_tbl[6];
    logic [31:0] pool[8];

    initial begin
        int first, second, c, r, k;
        logic [31:0] a;

        good_tbl[0] = '{0, 1, 32'h1000, 32'hDEAD_BEEF, 32'h0,         0};
        good_tbl[1] = '{1, 0, 32'h1000, 32'h0,         32'hDEAD_BEEF, 0};
        good_tbl[2] = '{0, 1, 32'h0040, 32'h11,        32'hDEAD_BEEF, 0};
        good_tbl[3] = '{1, 0, 32'h0040, 32'h0,         32'h11,        0};
        good_tbl[4] = '{0, 1, 32'h3FFC, 32'hA5A5_0001, 32'h11,        0};
        good_tbl[5] = '{1, 0, 32'h3FFE, 32'h0,         32'hA5A5_0001, 0};

        bad_tbl[0] = '{1, 0, 32'h4000,      32'h0,  32'h0,         1};
        bad_tbl[1] = '{1, 0, 32'h1000,      32'h0,  32'hDEAD_BEEF, 1};
        bad_tbl[2] = '{1, 1, 32'h0020,      32'h5,  32'hDEAD_BEEF, 1};
        bad_tbl[3] = '{1, 0, 32'h0020,      32'h0,  32'h5,         1};
        bad_tbl[4] = '{0, 1, 32'h4000,      32'h99, 32'h5,         1};
        bad_tbl[5] = '{1, 0, 32'hFFFF_FFFC, 32'h0,  32'h0,         1};

        bus0.mem_read = 0; bus0.mem_write = 0; bus0.mem_addr = 0; bus0.mem_wdata = 0;
        bus1.mem_read = 0; bus1.mem_write = 0; bus1.mem_addr = 0; bus1.mem_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1;
        @(negedge clk);

        foreach (good_tbl[i]) begin
            xact(good_tbl[i].rd, good_tbl[i].wr, good_tbl[i].addr, good_tbl[i].wdata, $sformatf("good%0d", i));
            check($sformatf("good%0d_tbl_rdata", i), bus0.mem_rdata, good_tbl[i].exp_rdata);
            check($sformatf("good%0d_tbl_err", i), 32'(err0), 32'(good_tbl[i].exp_err));
        end

        // Reset while a write of 7 to 0x40 sits in WAIT.
        bus0.mem_write = 1; bus0.mem_addr = 32'h40; bus0.mem_wdata = 32'h7;
        @(posedge clk); @(negedge clk);
        rst_n = 0; bus0.mem_write = 0;
        @(negedge clk);
        rst_n = 1;
        k = 0;
        repeat (4) begin @(negedge clk); k += bus0.mem_resp; end
        check("rst_wait_no_resp", 32'(k), 32'h0);
        model_reset();
        check_reset_state("rst_wait");
        xact(1, 0, 32'h40, 32'h0, "rst_wait_old");
        check("rst_wait_old_value", bus0.mem_rdata, 32'h11);

        // MMIO window: console byte, halt, halt readback.
        xact(0, 1, 32'hFFFF_0000, 32'h141, "mmio_tx");
        xact(0, 1, 32'hFFFF_0004, 32'h1234, "mmio_halt");
        xact(1, 0, 32'hFFFF_0004, 32'h0, "mmio_rd");
        check("mmio_tx_byte",   32'(tx_data0),  MMIO ? 32'h41 : 32'h0);
        check("mmio_halt_flag", 32'(halt0),     MMIO ? 32'h1 : 32'h0);
        check("mmio_rd_value",  bus0.mem_rdata, MMIO ? 32'h1 : 32'h0);
        check("mmio_err",       32'(err0),      MMIO ? 32'h0 : 32'h1);

        foreach (bad_tbl[i]) begin
            xact(bad_tbl[i].rd, bad_tbl[i].wr, bad_tbl[i].addr, bad_tbl[i].wdata, $sformatf("bad%0d", i));
            check($sformatf("bad%0d_tbl_rdata", i), bus0.mem_rdata, bad_tbl[i].exp_rdata);
            check($sformatf("bad%0d_tbl_err", i), 32'(err0), 32'(bad_tbl[i].exp_err));
        end

        // Random traffic over a pre-written pool plus error/MMIO addresses.
        foreach (pool[i]) begin
            pool[i] = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            xact(0, 1, pool[i], $urandom, $sformatf("pool%0d", i));
        end
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            case (r)
                6:       xact($urandom_range(0, 1) == 1, 1'b0, 32'h4000 + ($urandom_range(0, 255) << 2), $urandom, $sformatf("rnd%0d", i));
                7:       xact(1, 1, a, $urandom, $sformatf("rnd%0d", i));
                8:       xact(0, 1, 32'hFFFF_0000, $urandom, $sformatf("rnd%0d", i));
                9:       xact(1, 0, 32'hFFFF_0004, 32'h0, $sformatf("rnd%0d", i));
                default: xact($urandom_range(0, 1) == 1, ~bus0.mem_read, a, $urandom, $sformatf("rnd%0d", i));
            endcase
        end

        // LATENCY=1 instance: write, then a continuously held read.
        bus1.mem_write = 1; bus1.mem_addr = 32'h1000; bus1.mem_wdata = 32'h13;
        @(posedge clk); @(negedge clk);
        check("l1_wr_resp", 32'(bus1.mem_resp), 32'h1);
        bus1.mem_write = 0;
        @(negedge clk);
        bus1.mem_read = 1;
        first = -1; second = -1;
        for (c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus1.mem_resp) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
                check($sformatf("l1_rdata_c%0d", c), bus1.mem_rdata, 32'h13);
            end
        end
        bus1.mem_read = 0;
        check("l1_first_resp", 32'(first), 32'h1);
        check("l1_resp_spacing", 32'(second - first), 32'h2);
        check("l1_err", 32'(err1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
